piso_tx: RTL and testbench



---
 rtl/piso_tx.sv | 89 ++++++++
 tb/tb_piso_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: valid/ready loaded parallel-in/serial-out transmitter, MSB first, one bit per en_i strobe.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             en_i,
    output logic             d_o,
    output logic             frame_o,
    output logic             done_o
);
    localparam int CW = $clog2(Width + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [Width-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == IDLE && valid_i) begin
            state_d = SHIFT;
            shift_d = data_i;
            count_d = '0;
`ifdef PISO_TX_PARITY_EN
            par_d   = ^data_i;
`endif
        end else if (state_q == SHIFT && en_i) begin
            shift_d = {shift_q[Width-2:0], 1'b0};
            count_d = count_q + CW'(1);
            if (count_q == CW'(Width - 1)) begin
                count_d = '0;
`ifdef PISO_TX_PARITY_EN
                state_d = PAR;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
        end else if (state_q == PAR && en_i) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) par_q <= 1'b0;
        else       par_q <= par_d;
    end
    assign d_o = (state_q == SHIFT) ? shift_q[Width-1] : (state_q == PAR) ? par_q : 1'b0;
`else
    assign d_o = (state_q == SHIFT) ? shift_q[Width-1] : 1'b0;
`endif

    assign ready_o = (state_q == IDLE);
    assign frame_o = (state_q != IDLE);
    assign done_o  = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx with a behavioural SIPO in loopback.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk_i = 0, rst_i = 1, valid_i = 0, en_i = 0;
    logic [W-1:0] data_i = '0;
    logic         ready_o, d_o, frame_o, done_o;

    piso_tx #(.Width(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .en_i(en_i), .d_o(d_o), .frame_o(frame_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0, flen = 0, period = 1;
    logic [W-1:0] sipo = '0;
    logic [W-1:0] pend[$];
    logic [W-1:0] words[$];
    logic         bits[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input bit en, input bit junk);
        logic [W-1:0] w;
        bit loading;
        valid_i = 0;
        data_i  = '0;
        if (pend.size() > 0) begin
            valid_i = 1;
            data_i  = pend[0];
        end else if (junk && ready_o === 1'b0) begin
            valid_i = 1;
            data_i  = 8'h0F;
        end
        en_i = en;
        loading = (pend.size() > 0) && ready_o === 1'b1 && !rst_i;
        if (en && frame_o === 1'b1 && !rst_i) begin
            if (bits.size() > 0) chk("bit", d_o, bits.pop_front());
            else chk("extra_bit", frame_o, 0);
        end
        if (en && !rst_i) sipo = {sipo[W-2:0], d_o};
        if (loading) begin
            w = pend.pop_front();
            for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
            bits.push_back(^w);
            words.push_back({w[W-2:0], ^w});
`else
            words.push_back(w);
`endif
        end
        @(posedge clk_i);
        #1;
        if (frame_o === 1'b1) begin
            flen++;
            chk("busy_ready", ready_o, 0);
        end
        if (done_o === 1'b1) begin
            chk("done_ready", ready_o, 1);
            chk("done_frame", frame_o, 0);
            if (period == 1) chk("frame_len", flen, FLEN);
            flen = 0;
            if (words.size() > 0) chk("sipo", sipo, words.pop_front());
            else chk("spurious_done", done_o, 0);
        end
    endtask

    task automatic run(input int per, input bit junk);
        int c = 0;
        period = per;
        do begin
            cyc((c % per) == per - 1, junk);
            c++;
        end while (!(pend.size() == 0 && bits.size() == 0 && words.size() == 0 && frame_o === 1'b0) && c < 400);
        chk("timeout", (c < 400) ? 1 : 0, 1);
    endtask

    initial begin
        repeat (2) cyc(0, 0);
        rst_i = 0;
        chk("rst_ready", ready_o, 1);
        chk("rst_d", d_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_done", done_o, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 0);
            chk("idle_ready", ready_o, 1);
            chk("idle_d", d_o, 0);
            chk("idle_frame", frame_o, 0);
            chk("idle_done", done_o, 0);
        end
        pend.push_back(8'hA5);
        run(4, 0);
        pend.push_back(8'h3C);
        pend.push_back(8'hC3);
        run(1, 0);
        pend.push_back(8'hF0);
        run(1, 1);
        pend.push_back(8'hFF);
        period = 1;
        repeat (4) cyc(1, 0);
        rst_i = 1;
        cyc(0, 0);
        rst_i = 0;
        chk("abort_d", d_o, 0);
        chk("abort_frame", frame_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_done", done_o, 0);
        bits.delete();
        words.delete();
        flen = 0;
        cyc(1, 0);
        chk("abort_no_done", done_o, 0);
        pend.push_back(8'h81);
        run(1, 0);
`ifdef PISO_TX_PARITY_EN
        pend.push_back(8'h07);
        run(2, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
